// File: rtl/fam_block_framer.sv
// fam_block_framer: buffers a complex sample stream in a 2*NP circular buffer
// and emits P overlapping blocks of Np samples, advancing Np/4 per block, on an
// AXI-Stream master port feeding the FFT core.
// Optional feature macro: FRAMER_BLOCK_IDX_EN adds o_block_index.
//
// Handshakes: an input sample transfers on a rising edge where
// i_sample_valid & o_sample_ready & i_enable; an output beat transfers where
// o_s_axis_data_tvalid & i_s_axis_data_tready & i_enable. Once tvalid is high,
// tvalid/tdata/tlast hold until the beat transfers; tvalid is a register and
// never depends combinationally on tready.
module fam_block_framer #(
    parameter int P       = 1024,
    parameter int NP      = 1024,
    parameter int NB_DATA = 16,
    localparam int PW     = $clog2(P)
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic [2:0]             i_NFFT_sel,
    input  logic [NB_DATA-1:0]     i_sample_re,
    input  logic [NB_DATA-1:0]     i_sample_im,
    input  logic                   i_sample_valid,
    output logic                   o_sample_ready,
    output logic [2*NB_DATA-1:0]   o_s_axis_data_tdata,
    output logic                   o_s_axis_data_tvalid,
    input  logic                   i_s_axis_data_tready,
    output logic                   o_s_axis_data_tlast,
    output logic                   o_frame_done,
    output logic [1:0]             o_dbg_state
`ifdef FRAMER_BLOCK_IDX_EN
    ,
    output logic [PW-1:0]          o_block_index
`endif
);

    localparam int AW = $clog2(2*NP);   // buffer address width
    localparam int OW = AW + 1;         // pointer/occupancy width (extra bit: full vs empty)
    localparam int NW = $clog2(NP) + 1; // holds Np up to NP inclusive
    localparam int CW = $clog2(NP);     // read counter 0..Np-1
    localparam int DW = 2*NB_DATA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [DW-1:0]   r_mem [2*NP];
    logic [OW-1:0]   r_wr_ptr, r_base;
    logic [CW-1:0]   r_rd_cnt;
    logic [PW-1:0]   r_p;
    logic [NW-1:0]   r_np, r_l;
    logic            r_last_issued;
    logic            r_ready;
    logic            r_tvalid, r_tlast;
    logic [DW-1:0]   r_tdata;

    logic [OW-1:0]   w_occ, w_occ_next, w_np_ext, w_l_ext;
    logic [AW-1:0]   w_rd_addr;
    logic [11:0]     w_np_req;
    logic [NW-1:0]   w_np_new;
    logic            w_wr_fire, w_out_hs, w_last_hs, w_issue, w_rd_is_last;

    assign w_occ        = r_wr_ptr - r_base;
    assign w_np_ext     = {{(OW-NW){1'b0}}, r_np};
    assign w_l_ext      = {{(OW-NW){1'b0}}, r_l};
    assign w_wr_fire    = i_enable & i_sample_valid & r_ready;
    assign w_out_hs     = i_enable & r_tvalid & i_s_axis_data_tready;
    assign w_last_hs    = w_out_hs & r_tlast;
    assign w_rd_is_last = ({1'b0, r_rd_cnt} == (r_np - NW'(1)));
    assign w_issue      = i_enable & (r_state == S_SEND) & ~r_last_issued
                        & (~r_tvalid | i_s_axis_data_tready);
    assign w_rd_addr    = AW'(r_base + {{(OW-CW){1'b0}}, r_rd_cnt});

    // Requested block length, clamped to the buffer's maximum block length.
    assign w_np_req = 12'd16 << i_NFFT_sel;
    assign w_np_new = (w_np_req > 12'(NP)) ? NW'(NP) : w_np_req[NW-1:0];

    // Occupancy after this cycle's write and block advance; IDLE start clears it.
    assign w_occ_next = (r_state == S_IDLE) ? '0
                      : w_occ + OW'(w_wr_fire) - (w_last_hs ? w_l_ext : '0);

    // Next-state logic; nothing moves while the block is disabled.
    always_comb begin
        w_state_next = r_state;
        if (i_enable) begin
            case (r_state)
                S_IDLE: if (i_start) w_state_next = S_FILL;
                S_FILL: if (w_occ >= w_np_ext) w_state_next = S_SEND;
                S_SEND: begin
                    if (w_last_hs) begin
                        if (r_p == PW'(P-1))            w_state_next = S_DONE;
                        else if (w_occ_next >= w_np_ext) w_state_next = S_SEND;
                        else                             w_state_next = S_FILL;
                    end
                end
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Sample buffer write port; no reset needed on storage.
    always_ff @(posedge clock) begin
        if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= {i_sample_im, i_sample_re};
    end

    // Pointers, block counters, ready and the registered output stage.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_base        <= '0;
            r_rd_cnt      <= '0;
            r_p           <= '0;
            r_np          <= '0;
            r_l           <= '0;
            r_last_issued <= 1'b0;
            r_ready       <= 1'b0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
        end else if (i_enable) begin
            // Ready is derived from next-cycle occupancy so it can never admit an overflow write.
            r_ready <= ((w_state_next == S_FILL) || (w_state_next == S_SEND))
                       && (w_occ_next < OW'(2*NP));
            if (r_state == S_IDLE && i_start) begin
                r_wr_ptr      <= '0;
                r_base        <= '0;
                r_rd_cnt      <= '0;
                r_p           <= '0;
                r_last_issued <= 1'b0;
                r_np          <= w_np_new;
                r_l           <= w_np_new >> 2;
            end else begin
                if (w_wr_fire) r_wr_ptr <= r_wr_ptr + OW'(1);
                if (w_issue) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_mem[w_rd_addr];
                    r_tlast  <= w_rd_is_last;
                    if (w_rd_is_last) r_last_issued <= 1'b1;
                    else              r_rd_cnt      <= r_rd_cnt + CW'(1);
                end else if (w_out_hs) begin
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_tdata  <= '0;
                end
                if (w_last_hs) begin
                    r_base        <= r_base + w_l_ext;
                    r_p           <= r_p + PW'(1);
                    r_rd_cnt      <= '0;
                    r_last_issued <= 1'b0;
                end
            end
        end
    end

`ifdef FRAMER_BLOCK_IDX_EN
    logic [PW-1:0] r_bidx;
    // Block index travels with tdata: loaded on issue, cleared when the stage empties.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset)                   r_bidx <= '0;
        else if (i_enable && w_issue)  r_bidx <= r_p;
        else if (i_enable && w_out_hs) r_bidx <= '0;
    end
    assign o_block_index = r_bidx;
`endif

    assign o_sample_ready       = r_ready;
    assign o_s_axis_data_tdata  = r_tdata;
    assign o_s_axis_data_tvalid = r_tvalid;
    assign o_s_axis_data_tlast  = r_tlast;
    assign o_frame_done         = (r_state == S_DONE);
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_fam_block_framer.sv
// Directed bench for fam_block_framer (P=4, NP=64). Optional macro
// FRAMER_BLOCK_IDX_EN enables o_block_index checks.
module tb_fam_block_framer;

  localparam int P = 4;
  localparam int NP = 64;
  localparam int NB = 16;

  logic          clock = 1'b0;
  logic          i_reset, i_enable, i_start;
  logic [2:0]    i_NFFT_sel;
  logic [NB-1:0] i_sample_re, i_sample_im;
  logic          i_sample_valid, o_sample_ready;
  logic [2*NB-1:0] o_tdata;
  logic          o_tvalid, i_tready, o_tlast, o_frame_done;
  logic [1:0]    o_dbg_state;
`ifdef FRAMER_BLOCK_IDX_EN
  logic [1:0]    o_block_index;
`endif

  int errors = 0;
  int checks = 0;
  logic [34:0] exp_q[$];

  fam_block_framer #(.P(P), .NP(NP), .NB_DATA(NB)) dut (
    .clock(clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_start(i_start),
    .i_NFFT_sel(i_NFFT_sel),
    .i_sample_re(i_sample_re),
    .i_sample_im(i_sample_im),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_s_axis_data_tdata(o_tdata),
    .o_s_axis_data_tvalid(o_tvalid),
    .i_s_axis_data_tready(i_tready),
    .o_s_axis_data_tlast(o_tlast),
    .o_frame_done(o_frame_done),
    .o_dbg_state(o_dbg_state)
`ifdef FRAMER_BLOCK_IDX_EN
    ,
    .o_block_index(o_block_index)
`endif
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, o_tvalid, 0);
    chk({tag, "_tdata"}, o_tdata, 0);
    chk({tag, "_tlast"}, o_tlast, 0);
    chk({tag, "_done"}, o_frame_done, 0);
    chk({tag, "_ready"}, o_sample_ready, 0);
    chk({tag, "_state"}, o_dbg_state, 0);
`ifdef FRAMER_BLOCK_IDX_EN
    chk({tag, "_bidx"}, o_block_index, 0);
`endif
  endtask

  // Drives one frame: sample source, tready pattern, beat scoreboard and done checks.
  // abort_at >= 0 asserts reset while that beat index is presented.
  task automatic run_frame(input string name, input int sel, input int gap, input bit rnd,
                           input int abort_at, input logic [15:0] base_val);
    int np, l, sent, beats, done_cnt, done_cyc, last_cyc, fill_cyc, total;
    bit fire_in, finished, prev_stall, seen_tv;
    logic [32:0] prev_beat;
    logic [34:0] e;
    logic [15:0] re;
    np = ((16 << sel) > NP) ? NP : (16 << sel);
    l = np / 4;
    total = P * np;
    exp_q.delete();
    for (int b = 0; b < P; b++)
      for (int k = 0; k < np; k++) begin
        re = base_val + 16'(b * l + k);
        exp_q.push_back({2'(b), (k == np - 1), re ^ 16'hA5A5, re});
      end
    sent = 0; beats = 0; done_cnt = 0; done_cyc = -10; last_cyc = -20; fill_cyc = -100;
    finished = 0; prev_stall = 0; seen_tv = 0; prev_beat = '0;

    @(posedge clock); #1;
    i_NFFT_sel = 3'(sel); i_start = 1'b1; i_sample_valid = 1'b0; i_tready = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;

    for (int c = 0; c < 4000 && !finished; c++) begin
      i_sample_valid = ((c % gap) == 0);
      i_sample_re = base_val + 16'(sent);
      i_sample_im = (base_val + 16'(sent)) ^ 16'hA5A5;
      i_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      fire_in = i_sample_valid & o_sample_ready;
      if (abort_at >= 0 && o_tvalid && beats == abort_at) begin
        i_reset = 1'b1;
        #1;
        chk_outputs_zero({name, "_abort"});
        @(posedge clock); #1;
        i_reset = 1'b0;
        i_sample_valid = 1'b0;
        return;
      end
      if (o_frame_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (prev_stall) begin
        chk({name, "_stall_valid"}, o_tvalid, 1);
        chk({name, "_stall_hold"}, {o_tlast, o_tdata}, prev_beat);
      end
      if (o_tvalid && !seen_tv) begin
        seen_tv = 1;
        chk({name, "_fill_before_tvalid"}, (sent >= np), 1);
        chk({name, "_first_latency"}, ((c - fill_cyc) <= 3), 1);
      end
      if (o_tvalid && i_tready) begin
        chk({name, "_beat_in_range"}, (beats < total), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({name, "_tdata"}, o_tdata, e[31:0]);
          chk({name, "_tlast"}, o_tlast, e[32]);
`ifdef FRAMER_BLOCK_IDX_EN
          chk({name, "_bidx"}, o_block_index, e[34:33]);
`endif
        end
        beats++;
        last_cyc = c;
      end
      prev_stall = o_tvalid & ~i_tready;
      prev_beat = {o_tlast, o_tdata};
      if (done_cnt > 0 && c >= done_cyc + 2) finished = 1;
      @(posedge clock); #1;
      if (fire_in) begin
        sent++;
        if (sent == np) fill_cyc = c;
      end
    end
    i_sample_valid = 1'b0;
    i_tready = 1'b1;
    chk({name, "_beat_count"}, beats, total);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_done_timing"}, done_cyc, last_cyc + 1);
    chk({name, "_idle_after"}, o_dbg_state, 0);
    chk({name, "_done_low_after"}, o_frame_done, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_start = 1'b0; i_NFFT_sel = 3'd0;
    i_sample_re = '0; i_sample_im = '0; i_sample_valid = 1'b0; i_tready = 1'b1;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk_outputs_zero("reset");
    i_reset = 1'b0;
    @(posedge clock); #1;
    chk_outputs_zero("idle");

    // Np=16, L=4, ramp input, tready high
    run_frame("np16_full", 0, 1, 1'b0, -1, 16'h0000);
    // same stimulus, tready toggled randomly
    run_frame("np16_stall", 0, 1, 1'b1, -1, 16'h0000);
    // input valid 1-in-3
    run_frame("np16_gap3", 0, 3, 1'b0, -1, 16'h0000);
    // sel=7 clamps to NP=64, L=16
    run_frame("sel7_clamp", 7, 1, 1'b0, -1, 16'h0100);
    // Np=32 with gaps and stalls together
    run_frame("np32_mix", 1, 2, 1'b1, -1, 16'h0050);
    // reset on beat 7 of block 2, then a clean frame from new input
    run_frame("abort", 0, 1, 1'b0, 2 * 16 + 7, 16'h0200);
    @(posedge clock); #1;
    chk_outputs_zero("post_abort");
    run_frame("after_abort", 0, 1, 1'b0, -1, 16'h0300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
